// File: rtl/multiplier10_seq.sv
// Sequential shift-and-add unsigned multiplier: p = a * b after W iterations.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request, sampled only in IDLE or DONE
//   a, b  - W-bit multiplicand / multiplier, captured on the accepting edge
//   busy  - high while iterating (RUN)
//   done  - one-cycle pulse when p becomes valid
//   p     - 2W-bit product, held until the next completion or reset
module multiplier10_seq #(
    parameter int unsigned W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    output logic                busy,
    output logic                done,
    output logic [2*W-1:0]      p
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   acc, acc_nxt;
    logic [PW-1:0]   mcand, mcand_nxt;
    logic [W-1:0]    mplier, mplier_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            busy_nxt, done_nxt;
    logic [PW-1:0]   p_nxt;
    logic [PW-1:0]   acc_sum;

    // Partial-product accumulate for the current multiplier bit.
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            p      <= p_nxt;
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        p_nxt      = p;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt  = RUN;
                    acc_nxt    = '0;
                    mcand_nxt  = PW'(a);
                    mplier_nxt = b;
                    cnt_nxt    = '0;
                    busy_nxt   = 1'b1;
                end else begin
                    state_nxt  = IDLE;
                end
            end
            RUN: begin
                acc_nxt    = acc_sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    // Final iteration: publish the sum including this edge's add.
                    p_nxt     = acc_sum;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    busy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplier10_seq.sv
// Directed and randomized self-checking bench for multiplier10_seq.
module tb_multiplier10_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  a;
    logic [9:0]  b;
    logic        busy;
    logic        done;
    logic [19:0] p;

    int checks = 0;
    int errors = 0;

    multiplier10_seq #(.W(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; checks latency, busy profile, product and hold.
    task automatic run_op(input logic [9:0] va, input logic [9:0] vb, input logic [19:0] exp);
        int cyc;
        int bad_busy;
        a = va;
        b = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 10'h155;
        b = 10'h2aa;
        cyc = 0;
        bad_busy = 0;
        while (!done && cyc < 40) begin
            if (!busy) bad_busy++;
            tick();
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd10);
        chk("busy_during_run", 32'(bad_busy), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("product", 32'(p), 32'(exp));
        tick();
        chk("done_falls", 32'(done), 32'd0);
        chk("product_hold", 32'(p), 32'(exp));
    endtask

    initial begin
        int cyc;
        int t_first;
        int pulses;
        int bad_busy;
        logic [9:0] ra;
        logic [9:0] rb;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_p", 32'(p), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Maximum operands, typical operands, zero operand.
        run_op(10'd1023, 10'd1023, 20'd1046529);
        run_op(10'd1000, 10'd999, 20'd999000);
        run_op(10'd0, 10'd777, 20'd0);
        run_op(10'd777, 10'd0, 20'd0);
        run_op(10'd1, 10'd1023, 20'd1023);

        // Back-to-back with start held high.
        a = 10'd12;
        b = 10'd34;
        start = 1'b1;
        tick();
        a = 10'd5;
        b = 10'd6;
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        t_first = cyc;
        chk("b2b_first_latency", 32'(cyc), 32'd10);
        chk("b2b_first_p", 32'(p), 32'd408);
        chk("b2b_busy_in_done", 32'(busy), 32'd0);
        tick();
        cyc++;
        start = 1'b0;
        chk("b2b_reload_busy", 32'(busy), 32'd1);
        chk("b2b_reload_done", 32'(done), 32'd0);
        chk("b2b_p_held", 32'(p), 32'd408);
        bad_busy = 0;
        while (!done && cyc < 80) begin
            if (!busy) bad_busy++;
            tick();
            cyc++;
        end
        chk("b2b_gap", 32'(cyc - t_first), 32'd11);
        chk("b2b_busy_run", 32'(bad_busy), 32'd0);
        chk("b2b_second_p", 32'(p), 32'd30);
        tick();
        chk("b2b_done_falls", 32'(done), 32'd0);

        // start and operand changes during RUN are ignored.
        a = 10'd7;
        b = 10'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            if (cyc == 3 || cyc == 7) begin
                start = 1'b1;
                a = 10'd500;
                b = 10'd600;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("ignore_latency", 32'(cyc), 32'd10);
        chk("ignore_p", 32'(p), 32'd63);
        tick();
        chk("ignore_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN.
        a = 10'd100;
        b = 10'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_p", 32'(p), 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("no_done_after_reset", 32'(pulses), 32'd0);
        run_op(10'd3, 10'd3, 20'd9);

        // Randomized operands against a reference product.
        for (int i = 0; i < 2000; i++) begin
            ra = 10'($urandom_range(0, 1023));
            rb = 10'($urandom_range(0, 1023));
            run_op(ra, rb, 20'(ra) * 20'(rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier10_seq.md
# multiplier10_seq

Sequential shift-and-add unsigned multiplier: takes two W-bit operands and produces a 2W-bit product after a fixed W-cycle iteration. It is the multiplying counterpart of the team's restoring divider. It replaces wide combinational constant/variable multiplies in the VGA arithmetic path, such as remainder rescaling between division stages, where a fixed multi-cycle latency is acceptable. It runs on the pixel-domain clock and uses a start/done handshake.

## Interface
- W, 10: operand width; product width is 2W.
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  W  multiplicand; captured on the accepting edge.
- b  input  W  multiplier; captured on the accepting edge.
- busy  output  1  high while an operation is iterating (state RUN).
- done  output  1  one-cycle pulse when p becomes valid.
- p  output  2W  product; holds its value until the next completion or reset.

## Operation
- State machine:
  - IDLE: start=1 → load, go to RUN.
  - RUN: iterates W times, then goes to DONE.
  - DONE: start=1 → load, go to RUN; otherwise go to IDLE.
- Load:
  - mcand (2W bits) ← zero-extended a.
  - mplier (W bits) ← b.
  - acc (2W bits) ← 0.
  - cnt ← 0.
- Each RUN edge:
  - if mplier[0], acc ← acc + mcand (mod 2^2W; overflow cannot occur for unsigned W×W).
  - mcand ← mcand << 1.
  - mplier ← mplier >> 1.
  - cnt ← cnt + 1.
- RUN edge with cnt = W−1 is the final iteration:
  - p ← final acc value, including this edge's add.
  - done ← 1.
  - state ← DONE.
- Result rules:
  - p = a × b exactly (unsigned).
  - No early termination: latency is independent of operand values, including zero.
- start in RUN is ignored. Operands are not re-sampled, and busy/done are unaffected.
- a and b may change freely after the accepting edge.
- cnt width is ceil(log2(W))+1 bits; it wraps only via reload.
- Reset (asynchronous, any time including mid-RUN):
  - state = IDLE.
  - acc, mcand, mplier, cnt = 0.
  - p = 0, busy = 0, done = 0.
  - The in-flight operation is discarded and no done pulse is produced for it.

## Timing
- Edge E0: start=1 sampled in IDLE/DONE → busy=1 after E0.
- Edges E1..EW: iterations. After EW: busy=0, done=1, p valid.
- Edge EW+1:
  - done=0.
  - If start=1 at EW+1, the next operation loads; busy=1 and p still holds the previous result until the next completion.
- Throughput: one product per W+1 cycles with back-to-back start; latency is W edges from the accepting edge to done.
- busy and done are registered outputs, never high simultaneously.
- p changes only on a completion edge or on reset.

## Test plan
- Reset then 1023×1023 (W=10) → busy high 10 cycles, done one cycle after E10, p=1046529; p holds after done falls.
- 1000×999 → p=999000. Then 0×777 → p=0 with identical 10-cycle latency (no early exit).
- Back-to-back: start held high; 12×34 then 5×6 → done pulses exactly 11 cycles apart, p=408 then p=30, busy low only during each DONE cycle.
- start pulsed and a/b changed at cycles 3 and 7 of RUN for 7×9 → ignored; p=63 at the original completion time.
- Assert rst at RUN cycle 5 of 100×100 → outputs 0 immediately (asynchronous), no done pulse. A subsequent 3×3 gives p=9 after 10 cycles.
- Randomized 2000 operand pairs against a reference model: p=a×b, done exactly once per accepted start.
